// File: rtl/blockmem2p_reader.sv
// blockmem2p_reader: read-side engine for the two-port block memory.
// Accepts a (start address, length) command and issues reads on port B.
// Returned words go through a small credit-controlled FIFO and leave on a
// valid/ready stream with tlast. The FIFO is sized so that it can never overflow.
`timescale 1ns/1ps

module blockmem2p_reader #(
  parameter  int G_MEMWIDTH  = 32,
  parameter  int G_MEMDEPTH  = 1024,
  parameter  int G_RDLATENCY = 1,
  localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  localparam int G_LENWIDTH  = G_ADDRWIDTH + 1
) (
  input  logic                   clkb,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [G_ADDRWIDTH-1:0] cmd_addr,
  input  logic [G_LENWIDTH-1:0]  cmd_len,
  output logic                   enb,
  output logic [G_ADDRWIDTH-1:0] addrb,
  input  logic [G_MEMWIDTH-1:0]  doutb,
  output logic [G_MEMWIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   busy
);

  localparam int FIFO_DEPTH = G_RDLATENCY + 2;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                  state;
  logic [G_ADDRWIDTH-1:0]  cur;
  logic [G_LENWIDTH-1:0]   remaining;
  logic                    issue_last;
  logic [G_RDLATENCY-1:0]  tag_valid;
  logic [G_RDLATENCY-1:0]  tag_last;
  logic [G_MEMWIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic                    fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        inflight;

  logic                    start;
  logic                    read_issue;
  logic                    issue;
  logic                    push;
  logic                    push_last;
  logic                    load;
  logic                    credit_ok;
  logic [CNT_W:0]          occupied;

  function automatic logic [G_ADDRWIDTH-1:0] next_addr(input logic [G_ADDRWIDTH-1:0] a);
    return (a == G_ADDRWIDTH'(G_MEMDEPTH - 1)) ? '0 : a + G_ADDRWIDTH'(1);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: words in storage plus reads still in flight must stay below FIFO_DEPTH;
  // a word leaving storage for the head register this edge frees its slot.
  always_comb begin
    push       = tag_valid[G_RDLATENCY-1];
    push_last  = tag_last[G_RDLATENCY-1];
    load       = (fifo_count != '0) && (!m_tvalid || m_tready);
    occupied   = {1'b0, fifo_count} + {1'b0, inflight} - {{CNT_W{1'b0}}, load};
    credit_ok  = occupied < (CNT_W + 1)'(FIFO_DEPTH);
    start      = (state == S_IDLE) && cmd_valid && cmd_ready && (cmd_len != '0);
    read_issue = (state == S_READ) && (remaining != '0) && credit_ok;
    issue      = start || read_issue;
  end

  // Command FSM: accepts commands, issues port-B reads, waits for the stream to drain.
  always_ff @(posedge clkb or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      enb        <= 1'b0;
      addrb      <= '0;
      issue_last <= 1'b0;
      cur        <= '0;
      remaining  <= '0;
    end else begin
      enb        <= 1'b0;
      issue_last <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (start) begin
            enb        <= 1'b1;
            addrb      <= cmd_addr;
            cur        <= next_addr(cmd_addr);
            remaining  <= cmd_len - G_LENWIDTH'(1);
            issue_last <= (cmd_len == G_LENWIDTH'(1));
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= (cmd_len == G_LENWIDTH'(1)) ? S_DRAIN : S_READ;
          end
        end
        S_READ: begin
          if (read_issue) begin
            enb        <= 1'b1;
            addrb      <= cur;
            cur        <= next_addr(cur);
            remaining  <= remaining - G_LENWIDTH'(1);
            issue_last <= (remaining == G_LENWIDTH'(1));
            if (remaining == G_LENWIDTH'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((fifo_count == '0) && (inflight == '0) && !m_tvalid) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return-path tags follow each read through the memory latency and count reads in flight.
  always_ff @(posedge clkb or negedge resetn) begin
    if (!resetn) begin
      tag_valid <= '0;
      tag_last  <= '0;
      inflight  <= '0;
    end else begin
      tag_valid[0] <= enb;
      tag_last[0]  <= enb & issue_last;
      for (int i = 1; i < G_RDLATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
    end
  end

  // FIFO storage: captures returned data when its tag emerges; no reset needed.
  always_ff @(posedge clkb) begin
    if (push) begin
      fifo_data[wr_ptr] <= doutb;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  // FIFO pointers and the head register that drives the output stream.
  always_ff @(posedge clkb or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tlast    <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (load) begin
        rd_ptr   <= next_ptr(rd_ptr);
        m_tdata  <= fifo_data[rd_ptr];
        m_tlast  <= fifo_last[rd_ptr];
        m_tvalid <= 1'b1;
      end else if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(load);
    end
  end

  // The credit scheme must make a push into a full FIFO impossible.
  assert property (@(posedge clkb) disable iff (!resetn)
                   push |-> (fifo_count < CNT_W'(FIFO_DEPTH)));

endmodule
